pipelined_rca_adder: RTL and testbench

- Parametrised, pipelined successor to the team's 4-bit ripple-carry adder.
- Splits a WIDTH-bit add/subtract into NSTAGE = WIDTH/SLICE ripple slices, one slice per pipeline stage; the carry is registered between stages.
- Valid/ready streaming interface with backpressure; one result per cycle at full throughput.
- Sits in the datapath wherever wide adds must close timing that a single WIDTH-bit ripple chain cannot.

---
 rtl/pipelined_rca_adder.sv | 133 +++++++++++++
 tb/tb_pipelined_rca_adder.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_rca_adder.sv
// Pipelined ripple-carry add/subtract: WIDTH bits split into SLICE-bit ripple
// slices, one slice per stage, carry registered between stages, valid/ready flow.
module pipelined_rca_adder #(
    parameter int WIDTH = 16,
    parameter int SLICE = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             c_in,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             c_out,
    output logic             ovf
);
    // WIDTH must be a multiple of SLICE.
    localparam int NSTAGE = WIDTH / SLICE;

    logic             en;
    logic [WIDTH-1:0] yb;
    logic             cin0;

    // Subtraction is x + ~y + 1, so c_in is overridden in sub mode.
    assign yb   = sub ? ~y : y;
    assign cin0 = sub | c_in;

    generate
        for (genvar gi = 0; gi < NSTAGE; gi++) begin : g_stage
            localparam int LO = gi * SLICE;
            localparam int HI = LO + SLICE;

            logic [SLICE-1:0] a;
            logic [SLICE-1:0] b;
            logic             cin;
            logic             v_in;
            logic [SLICE:0]   add;
            logic [HI-1:0]    sum_d;
            logic [HI-1:0]    sum_q;
            logic             vld_q;

            if (gi == 0) begin : g_src
                assign a     = x[SLICE-1:0];
                assign b     = yb[SLICE-1:0];
                assign cin   = cin0;
                assign v_in  = in_valid;
                assign sum_d = add[SLICE-1:0];
            end else begin : g_src
                assign a     = g_stage[gi-1].g_fwd.opx_q[SLICE-1:0];
                assign b     = g_stage[gi-1].g_fwd.opy_q[SLICE-1:0];
                assign cin   = g_stage[gi-1].g_fwd.carry_q;
                assign v_in  = g_stage[gi-1].vld_q;
                assign sum_d = {add[SLICE-1:0], g_stage[gi-1].sum_q};
            end

            assign add = {1'b0, a} + {1'b0, b} + {{SLICE{1'b0}}, cin};

            // Data only loads on a valid beat, so bubbles leave the last result visible.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    vld_q <= 1'b0;
                    sum_q <= '0;
                end else if (en) begin
                    vld_q <= v_in;
                    if (v_in) begin
                        sum_q <= sum_d;
                    end
                end
            end

            if (gi < NSTAGE - 1) begin : g_fwd
                localparam int REM = WIDTH - HI;

                logic [REM-1:0] opx_d;
                logic [REM-1:0] opy_d;
                logic [REM-1:0] opx_q;
                logic [REM-1:0] opy_q;
                logic           carry_q;

                if (gi == 0) begin : g_op
                    assign opx_d = x[WIDTH-1:SLICE];
                    assign opy_d = yb[WIDTH-1:SLICE];
                end else begin : g_op
                    assign opx_d = g_stage[gi-1].g_fwd.opx_q[WIDTH-LO-1:SLICE];
                    assign opy_d = g_stage[gi-1].g_fwd.opy_q[WIDTH-LO-1:SLICE];
                end

                always_ff @(posedge clk or posedge rst) begin
                    if (rst) begin
                        opx_q   <= '0;
                        opy_q   <= '0;
                        carry_q <= 1'b0;
                    end else if (en && v_in) begin
                        opx_q   <= opx_d;
                        opy_q   <= opy_d;
                        carry_q <= add[SLICE];
                    end
                end
            end else begin : g_last
                logic c_msb_in;
                logic c_out_q;
                logic ovf_q;

                // Carry into the MSB recovered from the MSB sum bit and its operands.
                assign c_msb_in = add[SLICE-1] ^ a[SLICE-1] ^ b[SLICE-1];

                always_ff @(posedge clk or posedge rst) begin
                    if (rst) begin
                        c_out_q <= 1'b0;
                        ovf_q   <= 1'b0;
                    end else if (en && v_in) begin
                        c_out_q <= add[SLICE];
                        ovf_q   <= add[SLICE] ^ c_msb_in;
                    end
                end
            end
        end
    endgenerate

    assign out_valid = g_stage[NSTAGE-1].vld_q;
    assign s         = g_stage[NSTAGE-1].sum_q;
    assign c_out     = g_stage[NSTAGE-1].g_last.c_out_q;
    assign ovf       = g_stage[NSTAGE-1].g_last.ovf_q;

    // Whole pipeline freezes while a result waits on a busy consumer.
    assign en       = !(out_valid && !out_ready);
    assign in_ready = en;

endmodule

// File: tb/tb_pipelined_rca_adder.sv
// Directed bench for pipelined_rca_adder: a 16/4 instance and a 16/16 single-stage instance.
module tb_pipelined_rca_adder;
    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         out_ready;
    logic         c_in;
    logic         sub;
    logic [W-1:0] x;
    logic [W-1:0] y;

    logic         in_ready_a, out_valid_a, c_out_a, ovf_a;
    logic [W-1:0] s_a;
    logic         in_ready_b, out_valid_b, c_out_b, ovf_b;
    logic [W-1:0] s_b;

    always #5 clk = ~clk;

    pipelined_rca_adder #(.WIDTH(16), .SLICE(4)) dut_a (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_a),
        .x(x), .y(y), .c_in(c_in), .sub(sub),
        .out_valid(out_valid_a), .out_ready(out_ready),
        .s(s_a), .c_out(c_out_a), .ovf(ovf_a)
    );

    pipelined_rca_adder #(.WIDTH(16), .SLICE(16)) dut_b (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_b),
        .x(x), .y(y), .c_in(c_in), .sub(sub),
        .out_valid(out_valid_b), .out_ready(out_ready),
        .s(s_b), .c_out(c_out_b), .ovf(ovf_b)
    );

    typedef struct {
        logic [W-1:0] x;
        logic [W-1:0] y;
        logic         c_in;
        logic         sub;
        logic [W-1:0] s;
        logic         c_out;
        logic         ovf;
    } vec_t;

    vec_t vecs[10];
    int   errors = 0;
    int   checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic ov(input int w);
        return (w == 0) ? out_valid_a : out_valid_b;
    endfunction

    function automatic logic [W-1:0] sv(input int w);
        return (w == 0) ? s_a : s_b;
    endfunction

    function automatic logic cv(input int w);
        return (w == 0) ? c_out_a : c_out_b;
    endfunction

    function automatic logic fv(input int w);
        return (w == 0) ? ovf_a : ovf_b;
    endfunction

    task automatic drive(input vec_t v);
        x    = v.x;
        y    = v.y;
        c_in = v.c_in;
        sub  = v.sub;
    endtask

    task automatic drive_junk();
        x    = W'($urandom);
        y    = W'($urandom);
        c_in = 1'($urandom);
        sub  = 1'($urandom);
    endtask

    // Offer one beat, measure latency, check result and the single-cycle valid pulse.
    task automatic run_single(input vec_t v, input int w, input int exp_lat, input string tag);
        int lat;
        drive(v);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        drive_junk();
        lat = 1;
        while (!ov(w) && lat < 12) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, " latency"}, lat, exp_lat);
        check({tag, " s"}, sv(w), v.s);
        check({tag, " c_out"}, cv(w), v.c_out);
        check({tag, " ovf"}, fv(w), v.ovf);
        $display("%s: x=%h y=%h c_in=%b sub=%b -> s=%h c_out=%b ovf=%b lat=%0d",
                 tag, v.x, v.y, v.c_in, v.sub, sv(w), cv(w), fv(w), lat);
        @(posedge clk); #1;
        check({tag, " valid pulse"}, ov(w), 1'b0);
        check({tag, " s hold"}, sv(w), v.s);
    endtask

    initial begin
        vecs[0] = '{16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0};
        vecs[1] = '{16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[2] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
        vecs[3] = '{16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0};
        vecs[4] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
        vecs[5] = '{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0};
        vecs[6] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
        vecs[7] = '{16'hABCD, 16'h1111, 1'b0, 1'b0, 16'hBCDE, 1'b0, 1'b0};
        vecs[8] = '{16'h1234, 16'h1234, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0};
        vecs[9] = '{16'h0F0F, 16'h00F1, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0};

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        x = '0; y = '0; c_in = 1'b0; sub = 1'b0;

        @(posedge clk); #1;
        check("reset out_valid", out_valid_a, 1'b0);
        check("reset s", s_a, 16'h0000);
        check("reset c_out", c_out_a, 1'b0);
        check("reset ovf", ovf_a, 1'b0);
        rst = 1'b0;
        @(posedge clk); #1;
        check("in_ready after release", in_ready_a, 1'b1);

        for (int i = 0; i < 10; i++) begin
            run_single(vecs[i], 0, 4, $sformatf("vec%0d", i));
        end

        run_single(vecs[7], 1, 1, "slice16 vec7");
        run_single(vecs[2], 1, 1, "slice16 vec2");

        // Drain the 4-stage instance of the beats offered to the single-stage one.
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
        end

        // Stream of 8 beats, consumer stalls on cycles 6-8; junk offered while stalled.
        begin
            int nxt  = 0;
            int cons = 0;
            for (int cyc = 1; cyc <= 24; cyc++) begin
                logic exp_rdy;
                exp_rdy   = !(cyc >= 6 && cyc <= 8);
                out_ready = exp_rdy;
                if (nxt < 8) begin
                    in_valid = 1'b1;
                    if (exp_rdy) drive(vecs[nxt]);
                    else drive_junk();
                end else begin
                    in_valid = 1'b0;
                end
                #1;
                if (cyc <= 16) begin
                    check($sformatf("stream in_ready cyc%0d", cyc), in_ready_a, exp_rdy);
                end
                if (out_valid_a) begin
                    if (cons >= 8) begin
                        check($sformatf("stream extra beat cyc%0d", cyc), out_valid_a, 1'b0);
                    end else begin
                        check($sformatf("stream s beat%0d cyc%0d", cons, cyc), s_a, vecs[cons].s);
                        check($sformatf("stream c_out beat%0d cyc%0d", cons, cyc), c_out_a, vecs[cons].c_out);
                        check($sformatf("stream ovf beat%0d cyc%0d", cons, cyc), ovf_a, vecs[cons].ovf);
                        $display("stream cyc%0d: beat%0d s=%h c_out=%b ovf=%b out_ready=%b",
                                 cyc, cons, s_a, c_out_a, ovf_a, out_ready);
                        if (out_ready) cons++;
                    end
                end
                if (in_valid && exp_rdy) nxt++;
                @(posedge clk); #1;
            end
            check("stream beats consumed", cons, 8);
            out_ready = 1'b1;
            in_valid  = 1'b0;
        end

        // Reset with three beats in flight: none may ever emerge.
        begin
            int seen = 0;
            for (int i = 0; i < 3; i++) begin
                drive(vecs[i]);
                in_valid = 1'b1;
                @(posedge clk); #1;
            end
            in_valid = 1'b0;
            rst = 1'b1;
            #1;
            check("mid reset out_valid", out_valid_a, 1'b0);
            check("mid reset s", s_a, 16'h0000);
            @(posedge clk); #1;
            rst = 1'b0;
            @(posedge clk); #1;
            check("post reset in_ready", in_ready_a, 1'b1);
            for (int i = 0; i < 8; i++) begin
                if (out_valid_a) seen++;
                @(posedge clk); #1;
            end
            check("flushed beats emitted", seen, 0);
            $display("reset flush: %0d stale beats seen", seen);
            run_single(vecs[9], 0, 4, "post-reset vec9");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
